// File: rtl/rv_param_register_file.sv
// rv_param_register_file: parameterised RISC-V integer register file with
// combinational reads, optional write bypass and an FSM-driven scrub.
module rv_param_register_file #(
    parameter int XLEN           = 32,
    parameter int NREGS          = 32,
    parameter int NREAD          = 2,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset,
    input  logic                    we,
    input  logic [4:0]              rd,
    input  logic [XLEN-1:0]         indata,
    input  logic [5*NREAD-1:0]      rs,
    output logic [XLEN*NREAD-1:0]   outdata,
    input  logic                    clr_start,
    output logic                    busy,
    output logic                    wr_err
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nx;
    logic [4:0]      ptr, ptr_nx;
    logic [XLEN-1:0] x [NREGS];
    logic            rd_in_range, wr_ok;

    assign busy        = state == CLEAR;
    assign rd_in_range = {1'b0, rd} < 6'(NREGS);
    assign wr_ok       = we && !busy && rd != 5'd0 && rd_in_range;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == IDLE) begin
            state_nx = clr_start ? CLEAR : IDLE;
            ptr_nx   = clr_start ? 5'd1 : ptr;
        end else begin
            ptr_nx   = ptr + 5'd1;
            state_nx = (ptr == 5'(NREGS - 1)) ? IDLE : CLEAR;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state  <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ptr    <= 5'd1;
            wr_err <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            wr_err <= we && (busy || !rd_in_range);
        end
    end

    // No reset on the array: zeroing happens only through the scrub walk.
    always_ff @(posedge sys_clk) begin
        if (busy)
            x[ptr[AW-1:0]] <= '0;
        else if (wr_ok)
            x[rd[AW-1:0]] <= indata;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [4:0] a;
        assign a = rs[5*i +: 5];
        assign outdata[XLEN*i +: XLEN] =
            (busy || a == 5'd0 || {1'b0, a} >= 6'(NREGS)) ? '0 :
            (BYPASS != 0 && wr_ok && rd == a)             ? indata :
                                                            x[a[AW-1:0]];
    end
endmodule

// File: doc/rv_param_register_file.md
RV_PARAM_REGISTER_FILE -- requirements
Module: rv_param_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every register.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports; legal 1..3.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = scrub all registers to zero after reset.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: sys_clk, sys_reset.
REQ-007 sys_clk  input  1  rising-edge clock.
REQ-008 sys_reset  input  1  asynchronous active-low reset (0 = reset).
REQ-009 we  input  1  write enable for rd.
REQ-010 rd  input  5  destination index (RISC-V encoding width).
REQ-011 indata  input  XLEN  write data.
REQ-012 rs  input  5*NREAD  read indices; port i at bits [5i+4:5i].
REQ-013 outdata  output  XLEN*NREAD  read data; port i at bits [XLEN*i+XLEN-1:XLEN*i].
REQ-014 clr_start  input  1  request a software scrub of all registers.
REQ-015 busy  output  1  scrub in progress, registered.
REQ-016 wr_err  output  1  registered one-cycle error pulse for a rejected write.

Function
REQ-017 Register 0 SHALL read as 0 on every port; writes to index 0 SHALL be discarded without error.
REQ-018 Reads SHALL be combinational: outdata[i] = stored value of rs[i], zero latency.
REQ-019 Index >= NREGS on a read port SHALL return 0.
REQ-020 Write SHALL commit on the rising edge when we=1, busy=0, 0<rd<NREGS; value readable from the following cycle.
REQ-021 With BYPASS=1: we=1, busy=0, rd=rs[i], 0<rd<NREGS SHALL drive outdata[i]=indata in the same cycle; with BYPASS=0 the old value is driven.
REQ-022 wr_err SHALL be 1 for exactly the cycle after an edge where we=1 and (rd>=NREGS or busy=1); such writes SHALL be discarded.
REQ-023 FSM states: IDLE, CLEAR; scrub pointer ptr, 5 bits.
REQ-024 IDLE -> CLEAR on an edge with clr_start=1; ptr loaded with 1; busy=1 from the next cycle.
REQ-025 In CLEAR, each edge SHALL write 0 to x[ptr] and increment ptr; when ptr=NREGS-1 is cleared, state -> IDLE and busy=0 from the next cycle.
REQ-026 Scrub SHALL take exactly NREGS-1 cycles with busy=1.
REQ-027 While busy=1, all outdata SHALL be 0, bypass SHALL be inactive, clr_start SHALL be ignored.
REQ-028 clr_start and a legal write on the same IDLE edge: the write SHALL commit, and the scrub SHALL start on that same edge and then clear it.

Reset
REQ-029 sys_reset=0 SHALL immediately force wr_err=0 and ptr=1, independent of sys_clk.
REQ-030 CLEAR_ON_RESET=1: during reset, state=CLEAR and busy=1; scrub begins at the first edge after release and ends per REQ-025.
REQ-031 CLEAR_ON_RESET=0: during reset, state=IDLE and busy=0; register contents are undefined until written.
REQ-032 Reset asserted mid-scrub SHALL abort it and restart per REQ-030/REQ-031.
REQ-033 Register array SHALL NOT have a reset port; zeroing is done only by the scrub FSM.

Verification
REQ-034 Defaults, reset released -> busy=1 for 31 cycles, then 0; all rs=1..31 read 0.
REQ-035 we=1, rd=5, indata=32'hDEADBEEF, rs0=5, BYPASS=1 -> outdata0=DEADBEEF in that cycle; BYPASS=0 -> old value, DEADBEEF next cycle.
REQ-036 we=1, rd=0, indata=32'h1234 -> rs0=0 reads 0, wr_err stays 0.
REQ-037 NREGS=16: we=1, rd=20 -> wr_err=1 for one cycle, no register changes; rs0=20 reads 0.
REQ-038 x7=32'hA5A5A5A5, pulse clr_start -> busy=1 for 31 cycles, outdata=0 throughout; a write during busy gives wr_err=1; afterwards x7 reads 0.
REQ-039 sys_reset=0 at cycle 10 of a scrub -> busy stays 1; after release, a full 31-cycle scrub completes.
